// File: rtl/uart_pkg.sv
// Shared UART types and line-level constants for the transmit (and future receive) path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular-buffer FIFO with registered full flag; push is ignored while full, pop while empty.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  // Acceptance uses the registered flag only: a push alongside a pop while full is dropped.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter, 8N1 LSB first, frames sent back-to-back while data is queued.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit between data and stop).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic       busy,
  output logic       txd
);

  localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(UART_DATA_BITS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      txd_q, txd_d;
  logic                      busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_pop_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic                      push_acc;
  logic                      baud_done;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign push_acc  = wr_en && !fifo_full;
  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_pop_data;
          baud_d   = '0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          parity_d = uart_even_parity(fifo_pop_data);
`endif
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames leave no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_pop_data;
            state_d  = START;
`ifdef UART_TX_PARITY_EN
            parity_d = uart_even_parity(fifo_pop_data);
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase

    // Line level follows the next state so txd changes on the same edge as the FSM.
    case (state_d)
      START:   txd_d = UART_START_LEVEL;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_d;
`endif
      default: txd_d = UART_IDLE_LEVEL;
    endcase

    busy_d = (state_d != IDLE) || push_acc || (fifo_count != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= UART_IDLE_LEVEL;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;
  assign full = fifo_full;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at CLK_PER_BIT=4, FIFO_DEPTH=16 (8E1 when UART_TX_PARITY_EN is defined).
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int SLOTS = 11;
`else
  localparam int SLOTS = 10;
`endif
  localparam int FC = SLOTS * CPB;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, busy, txd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLK_PER_BIT (CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .full    (full),
    .busy    (busy),
    .txd     (txd)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp8n1;  // slot i of the frame is bit i: start, d0..d7, stop
    logic       par;     // even parity of data
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] slots_of(input logic [9:0] e, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, e[8:0]};
`else
    return {p & 1'b0, e};
`endif
  endfunction

  function automatic logic [10:0] model_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b01, d, 1'b0};
`endif
  endfunction

  // Each slot must hold its level for exactly CPB sampled cycles; busy must stay high.
  task automatic check_frame(input logic [10:0] exp, input string name);
    int busy_low = 0;
    for (int s = 0; s < SLOTS; s++) begin
      int bad = 0;
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (txd !== exp[s]) bad++;
        if (busy !== 1'b1) busy_low++;
      end
      chk($sformatf("%s slot%0d bad_cycles", name, s), bad, 0);
    end
    chk({name, " busy_low_cycles"}, busy_low, 0);
    $display("frame %s expected_slots=%03h", name, exp);
  endtask

  task automatic burst(input logic [7:0] base, input int n_wr, input int n_frames,
                       input bit collide, input string name);
    fork
      begin
        wr_en   = 1'b1;
        wr_data = base;
        for (int i = 1; i < n_wr; i++) begin
          @(negedge clk);
          wr_data = base + 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
      end
      begin
        for (int k = 0; k <= FC + 2; k++) begin
          @(negedge clk);
          if (k == 15) chk({name, " full_at_15"}, full, 0);
          if (k == 16) chk({name, " full_at_16"}, full, 1);
          if (k == 17) chk({name, " full_at_17"}, full, 1);
          if (k == FC) begin
            chk({name, " full_before_pop"}, full, 1);
            if (collide) begin
              wr_en   = 1'b1;
              wr_data = 8'hEE;
            end
          end
          if (k == FC + 1) begin
            chk({name, " full_after_pop"}, full, 0);
            if (collide) wr_en = 1'b0;
          end
          if (k == FC + 2) chk({name, " full_after_pop2"}, full, 0);
        end
      end
      begin
        @(negedge clk);
        chk({name, " txd_before_start"}, txd, 1);
        for (int f = 0; f < n_frames; f++)
          check_frame(model_frame(base + 8'(f)), $sformatf("%s_%02h", name, base + 8'(f)));
        @(negedge clk);
        chk({name, " busy_after"}, busy, 0);
        chk({name, " txd_after"}, txd, 1);
      end
    join
  endtask

  task automatic reset_mid(input logic [7:0] b0, input bit two, input string name);
    int bad = 0;
    wr_en   = 1'b1;
    wr_data = b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (two) wr_data = 8'h00;
        else     wr_en = 1'b0;
      end
      if (k == 1) wr_en = 1'b0;
    end
    // Now inside data bit 3 of the first frame.
    chk({name, " txd_bit3"}, txd, b0[3]);
    chk({name, " busy_bit3"}, busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk({name, " txd_after_reset"}, txd, 1);
    chk({name, " busy_after_reset"}, busy, 0);
    chk({name, " full_after_reset"}, full, 0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk({name, " quiet_cycles_bad"}, bad, 0);
    $display("reset_mid %s byte=%02h second=%0d", name, b0, two);
  endtask

  initial begin
    vecs[0] = '{data: 8'h55, exp8n1: 10'h2AA, par: 1'b0};
    vecs[1] = '{data: 8'h00, exp8n1: 10'h200, par: 1'b0};
    vecs[2] = '{data: 8'hFF, exp8n1: 10'h3FE, par: 1'b0};
    vecs[3] = '{data: 8'h01, exp8n1: 10'h202, par: 1'b1};
    vecs[4] = '{data: 8'h80, exp8n1: 10'h300, par: 1'b1};
    vecs[5] = '{data: 8'h3C, exp8n1: 10'h278, par: 1'b0};
    vecs[6] = '{data: 8'h07, exp8n1: 10'h20E, par: 1'b1};

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset txd", txd, 1);
    chk("reset busy", busy, 0);
    chk("reset full", full, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset busy", busy, 0);

    for (int v = 0; v < 7; v++) begin
      wr_en   = 1'b1;
      wr_data = vecs[v].data;
      @(negedge clk);
      wr_en = 1'b0;
      chk($sformatf("single_%02h txd_latency", vecs[v].data), txd, 1);
      chk($sformatf("single_%02h busy_latency", vecs[v].data), busy, 1);
      check_frame(slots_of(vecs[v].exp8n1, vecs[v].par), $sformatf("single_%02h", vecs[v].data));
      @(negedge clk);
      chk($sformatf("single_%02h busy_after", vecs[v].data), busy, 0);
      chk($sformatf("single_%02h txd_after", vecs[v].data), txd, 1);
      repeat (2) @(negedge clk);
    end

    wr_en   = 1'b1;
    wr_data = 8'hA5;
    fork
      begin
        @(negedge clk);
        wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
      end
      begin
        @(negedge clk);
        chk("b2b txd_latency", txd, 1);
        check_frame(slots_of(10'h34A, 1'b0), "b2b_A5");
        check_frame(slots_of(10'h278, 1'b0), "b2b_3C");
        @(negedge clk);
        chk("b2b busy_after", busy, 0);
      end
    join
    repeat (2) @(negedge clk);

    burst(8'h00, 18, 17, 1'b0, "ovf");
    repeat (2) @(negedge clk);
    burst(8'h40, 17, 17, 1'b1, "coll");
    repeat (2) @(negedge clk);

    reset_mid(8'hFF, 1'b1, "rst_ff");
    reset_mid(8'h00, 1'b0, "rst_00");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
